// File: rtl/bus_arbiter_n_if.sv
// Serial system bus arbitration signals between masters and arbiter.
// Ports: breq (masters->arbiter); bgrant, msel, bus_busy, preempt (arbiter->masters).
interface bus_arbiter_n_if #(
  parameter int NUM_MASTERS = 4
);
  localparam int MSEL_WIDTH =
    (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [NUM_MASTERS-1:0] breq;
  logic [NUM_MASTERS-1:0] bgrant;
  logic [MSEL_WIDTH-1:0]  msel;
  logic                   bus_busy;
  logic                   preempt;

  modport master (
    output breq,
    input  bgrant,
    input  msel,
    input  bus_busy,
    input  preempt
  );

  modport slave (
    input  breq,
    output bgrant,
    output msel,
    output bus_busy,
    output preempt
  );
endinterface

// File: rtl/bus_arbiter_n.sv
// N-master bus arbiter: fixed or round-robin, bounded tenure, 1-cycle turnaround.
// Ports: clk, rst (async high), bus (slave: breq in; bgrant/msel/bus_busy/preempt out).
module bus_arbiter_n #(
  parameter int NUM_MASTERS = 4,
  parameter int ARB_MODE    = 1,
  parameter int MAX_HOLD    = 16,
  parameter int HOLD_WIDTH  = 8
) (
  input  logic           clk,
  input  logic           rst,
  bus_arbiter_n_if.slave bus
);
  localparam int MSEL_WIDTH =
    (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam bit HOLD_EN = (MAX_HOLD != 0);
  localparam int LIM_I = (MAX_HOLD > 0) ?
    MAX_HOLD - 1 : (1 << HOLD_WIDTH) - 1;
  localparam logic [HOLD_WIDTH-1:0] HOLD_LIM =
    HOLD_WIDTH'(LIM_I);
  localparam logic [HOLD_WIDTH-1:0] HOLD_MAX = '1;
  localparam logic [MSEL_WIDTH-1:0] LAST_RST =
    MSEL_WIDTH'(NUM_MASTERS - 1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    TURN
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [MSEL_WIDTH-1:0]  msel_q;
  logic [MSEL_WIDTH-1:0]  msel_d;
  logic [MSEL_WIDTH-1:0]  last_q;
  logic [MSEL_WIDTH-1:0]  last_d;
  logic [HOLD_WIDTH-1:0]  cnt_q;
  logic [HOLD_WIDTH-1:0]  cnt_d;
  logic                   pre_q;
  logic                   pre_d;
  logic [MSEL_WIDTH-1:0]  fx_win;
  logic [MSEL_WIDTH-1:0]  rr_win;
  logic                   rr_hit;
  logic [MSEL_WIDTH-1:0]  win;
  logic [NUM_MASTERS-1:0] own_oh;
  logic                   own_req;
  logic                   others;
  logic                   hold_hit;
  int                     rr_idx;

  // lowest set index wins
  always_comb begin
    fx_win = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (bus.breq[MSEL_WIDTH'(i)]) begin
        fx_win = MSEL_WIDTH'(i);
      end
    end
  end

  // search upward from last_owner+1, last_owner itself last
  always_comb begin
    rr_win = last_q;
    rr_hit = 1'b0;
    rr_idx = 0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      rr_idx = (int'(last_q) + k) % NUM_MASTERS;
      if (!rr_hit && bus.breq[MSEL_WIDTH'(rr_idx)]) begin
        rr_hit = 1'b1;
        rr_win = MSEL_WIDTH'(rr_idx);
      end
    end
  end

  assign win = (ARB_MODE != 0) ? rr_win : fx_win;

  always_comb begin
    own_oh = '0;
    own_oh[msel_q] = 1'b1;
  end

  assign own_req  = |(bus.breq & own_oh);
  assign others   = |(bus.breq & ~own_oh);
  assign hold_hit = HOLD_EN && (cnt_q >= HOLD_LIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      msel_q  <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      msel_q  <= msel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
    end
  end

  always_comb begin
    state_d = state_q;
    msel_d  = msel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    pre_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (|bus.breq) begin
          state_d = GRANT;
          msel_d  = win;
          last_d  = win;
        end
      end
      GRANT: begin
        if (cnt_q != HOLD_MAX) begin
          cnt_d = cnt_q + HOLD_WIDTH'(1);
        end
        // a voluntary release is never reported as preemption
        if (!own_req) begin
          state_d = TURN;
          cnt_d   = '0;
        end else if (hold_hit && others) begin
          state_d = TURN;
          cnt_d   = '0;
          pre_d   = 1'b1;
        end
      end
      TURN: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    bus.bgrant = '0;
    if (state_q == GRANT) begin
      bus.bgrant = own_oh;
    end
  end

  assign bus.msel     = msel_q;
  assign bus.bus_busy = (state_q == GRANT);
  assign bus.preempt  = pre_q;

endmodule

// File: tb/tb_bus_arbiter_n.sv
// Bench for bus_arbiter_n: three builds (RR/4, fixed/4, RR/2) vs a
// behavioural model, directed scenarios plus random request traffic.
module tb_bus_arbiter_n;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bus_arbiter_n_if #(.NUM_MASTERS(4)) if0 ();
  bus_arbiter_n_if #(.NUM_MASTERS(4)) if1 ();
  bus_arbiter_n_if #(.NUM_MASTERS(2)) if2 ();

  bus_arbiter_n #(
    .NUM_MASTERS(4), .ARB_MODE(1),
    .MAX_HOLD(16), .HOLD_WIDTH(8)
  ) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));

  bus_arbiter_n #(
    .NUM_MASTERS(4), .ARB_MODE(0),
    .MAX_HOLD(5), .HOLD_WIDTH(8)
  ) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  bus_arbiter_n #(
    .NUM_MASTERS(2), .ARB_MODE(1),
    .MAX_HOLD(0), .HOLD_WIDTH(4)
  ) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

  int nm [3] = '{4, 4, 2};
  int md [3] = '{1, 0, 1};
  int mh [3] = '{16, 5, 0};

  // model: owner (-1 none), in-turnaround flag, grant cycles so far
  int own [3];
  bit trn [3];
  int ten [3];
  int lst [3];
  int esel [3];
  bit epre [3];

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm_s, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d t=%0t",
               nm_s, act, exp, $time);
    end
  endtask

  task automatic fail(string nm_s);
    checks++;
    errors++;
    $display("FAIL %s timeout t=%0t", nm_s, $time);
  endtask

  function automatic logic [15:0] req_of(int i);
    case (i)
      0: return 16'(if0.breq);
      1: return 16'(if1.breq);
      default: return 16'(if2.breq);
    endcase
  endfunction

  function automatic int gnt_of(int i);
    case (i)
      0: return int'(if0.bgrant);
      1: return int'(if1.bgrant);
      default: return int'(if2.bgrant);
    endcase
  endfunction

  function automatic int sel_of(int i);
    case (i)
      0: return int'(if0.msel);
      1: return int'(if1.msel);
      default: return int'(if2.msel);
    endcase
  endfunction

  function automatic int busy_of(int i);
    case (i)
      0: return int'(if0.bus_busy);
      1: return int'(if1.bus_busy);
      default: return int'(if2.bus_busy);
    endcase
  endfunction

  function automatic int pre_of(int i);
    case (i)
      0: return int'(if0.preempt);
      1: return int'(if1.preempt);
      default: return int'(if2.preempt);
    endcase
  endfunction

  function automatic int pick(int i, logic [15:0] r);
    int w;
    w = -1;
    if (md[i] == 0) begin
      for (int b = nm[i] - 1; b >= 0; b--)
        if (r[b]) w = b;
    end else begin
      for (int k = nm[i]; k >= 1; k--)
        if (r[(lst[i] + k) % nm[i]]) w = (lst[i] + k) % nm[i];
    end
    return w;
  endfunction

  task automatic mreset();
    for (int i = 0; i < 3; i++) begin
      own[i]  = -1;
      trn[i]  = 1'b0;
      ten[i]  = 0;
      lst[i]  = nm[i] - 1;
      esel[i] = 0;
      epre[i] = 1'b0;
    end
  endtask

  task automatic step(int i);
    logic [15:0] r;
    logic [15:0] oth;
    r = req_of(i);
    epre[i] = 1'b0;
    if (trn[i]) begin
      trn[i] = 1'b0;
    end else if (own[i] < 0) begin
      if (r != 16'd0) begin
        own[i]  = pick(i, r);
        esel[i] = own[i];
        lst[i]  = own[i];
        ten[i]  = 0;
      end
    end else begin
      oth = r & ~(16'd1 << own[i]);
      if (!r[own[i]]) begin
        own[i] = -1;
        trn[i] = 1'b1;
      end else if (mh[i] != 0 && ten[i] + 1 >= mh[i]
                   && oth != 16'd0) begin
        own[i]  = -1;
        trn[i]  = 1'b1;
        epre[i] = 1'b1;
      end else begin
        ten[i]++;
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) mreset();
    else for (int i = 0; i < 3; i++) step(i);
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("bgrant%0d", i), gnt_of(i),
            (own[i] < 0) ? 0 : (1 << own[i]));
        chk($sformatf("msel%0d", i), sel_of(i), esel[i]);
        chk($sformatf("busy%0d", i), busy_of(i),
            (own[i] < 0) ? 0 : 1);
        chk($sformatf("preempt%0d", i), pre_of(i),
            int'(epre[i]));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    if0.breq = '0;
    if1.breq = '0;
    if2.breq = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_grant(int i, string nm_s, output int o);
    o = -1;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (gnt_of(i) != 0) begin
        o = $clog2(gnt_of(i));
        break;
      end
    end
    if (o < 0) fail(nm_s);
  endtask

  function automatic logic [15:0] rnd(logic [15:0] v, int n);
    logic [15:0] r;
    r = v;
    for (int b = 0; b < n; b++) begin
      if (r[b]) begin
        if ($urandom_range(15, 0) == 0) r[b] = 1'b0;
      end else begin
        if ($urandom_range(5, 0) == 0) r[b] = 1'b1;
      end
    end
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int o;
    int n;
    int pc;
    int order [5] = '{0, 1, 2, 3, 0};
    if0.breq = '0;
    if1.breq = '0;
    if2.breq = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_bgrant", int'(if0.bgrant), 0);
    chk("rst_msel", int'(if0.msel), 0);
    chk("rst_busy", int'(if0.bus_busy), 0);
    rst = 1'b0;

    // single request, grant then release
    do_reset();
    if0.breq = 4'b0100;
    @(negedge clk);
    chk("t1_grant", int'(if0.bgrant), 4);
    chk("t1_msel", int'(if0.msel), 2);
    chk("t1_busy", int'(if0.bus_busy), 1);
    if0.breq = 4'b0000;
    @(negedge clk);
    chk("t1_turn", int'(if0.bgrant), 0);
    chk("t1_tbusy", int'(if0.bus_busy), 0);
    chk("t1_hold_msel", int'(if0.msel), 2);

    // round-robin with all four requesting
    do_reset();
    if0.breq = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_grant(0, "t2_wait", o);
      chk("t2_order", o, order[g]);
      if (o >= 0) begin
        repeat (2) @(negedge clk);
        chk("t2_hold", int'(if0.bgrant), 1 << o);
        if0.breq[o] = 1'b0;
        @(negedge clk);
        chk("t2_gap", int'(if0.bgrant), 0);
        if0.breq = 4'b1111;
      end
    end

    // fixed priority, re-win after release and after preempt
    do_reset();
    if1.breq = 4'b1010;
    @(negedge clk);
    chk("t3_first", int'(if1.bgrant), 2);
    if1.breq = 4'b1000;
    @(negedge clk);
    chk("t3_gap", int'(if1.bgrant), 0);
    if1.breq = 4'b1010;
    wait_grant(1, "t3_wait", o);
    chk("t3_again", o, 1);
    n = 0;
    for (int c = 0; c < 20; c++) begin
      if (int'(if1.bgrant) != 2) break;
      n++;
      @(negedge clk);
    end
    chk("t3_tenure", n, 5);
    chk("t3_pre", int'(if1.preempt), 1);
    wait_grant(1, "t3_wait2", o);
    chk("t3_rewin", o, 1);

    // tenure preemption on the default build
    do_reset();
    if0.breq = 4'b0001;
    @(negedge clk);
    chk("t4_g0", int'(if0.bgrant), 1);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (int'(if0.bgrant) != 1) break;
      n++;
      if (n == 5) if0.breq[2] = 1'b1;
      @(negedge clk);
    end
    chk("t4_tenure", n, 16);
    chk("t4_pre", int'(if0.preempt), 1);
    chk("t4_pbusy", int'(if0.bus_busy), 0);
    @(negedge clk);
    chk("t4_pre_once", int'(if0.preempt), 0);
    wait_grant(0, "t4_wait", o);
    chk("t4_next", o, 2);

    // lone owner is never preempted
    do_reset();
    if0.breq = 4'b0001;
    pc = 0;
    repeat (40) begin
      @(negedge clk);
      pc += int'(if0.preempt);
    end
    chk("t4_nopre", pc, 0);
    chk("t4_still", int'(if0.bgrant), 1);

    // two-master build
    do_reset();
    if2.breq = 2'b11;
    wait_grant(2, "t5_wait", o);
    chk("t5_first", o, 0);
    chk("t5_msel0", int'(if2.msel), 0);
    if2.breq = 2'b10;
    @(negedge clk);
    if2.breq = 2'b11;
    wait_grant(2, "t5_wait2", o);
    chk("t5_second", o, 1);
    chk("t5_msel1", int'(if2.msel), 1);

    // asynchronous reset mid-grant
    do_reset();
    if0.breq = 4'b1000;
    wait_grant(0, "t6_wait", o);
    chk("t6_owner", o, 3);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t6_async_g", int'(if0.bgrant), 0);
    chk("t6_async_m", int'(if0.msel), 0);
    chk("t6_async_b", int'(if0.bus_busy), 0);
    #2 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t6_regrant", int'(if0.bgrant), 8);
    chk("t6_msel", int'(if0.msel), 3);

    // random traffic on all builds
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if0.breq = 4'(rnd(16'(if0.breq), 4));
      if1.breq = 4'(rnd(16'(if1.breq), 4));
      if2.breq = 2'(rnd(16'(if2.breq), 2));
    end
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
